// File: rtl/rf_dump.sv
// rf_dump: walks a register-file read port and streams each register out
// over a valid/ready handshake, either as a full sweep or a single index.
module rf_dump #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        single,
    input  logic [4:0]  addr,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] ptr;
    logic       single_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In SEND out_valid is always high, so out_ready alone signals acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = out_last ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            single_q  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        single_q <= single;
                        ptr      <= single ? addr : 5'd0;
                    end
                end
                FETCH: begin
                    out_data  <= rd;
                    out_idx   <= ptr;
                    out_last  <= single_q | (ptr == LAST_IDX);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!out_last) ptr <= ptr + 5'd1;
                    end
                end
                DONE: begin
                    // Return ptr to 0 so ra reads index 0 whenever the block is idle.
                    ptr      <= '0;
                    single_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ra   = ptr;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump: directed tests for rf_dump against a behavioural register file
// model, with a background handshake/protocol monitor.
module tb_rf_dump;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        single = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [0:31];
    assign rd = (ra == 5'd0) ? 32'd0 : rf[ra];

    logic [4:0]  q_idx  [$];
    logic [31:0] q_data [$];
    logic        q_last [$];
    int          done_count = 0;

    rf_dump #(.NREG(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .single    (single),
        .addr      (addr),
        .ra        (ra),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Records every accepted word and every done pulse as seen at the edge.
    always @(posedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                q_idx.push_back(out_idx);
                q_data.push_back(out_data);
                q_last.push_back(out_last);
            end
            if (done) done_count++;
        end
    end

    logic        stall_prev = 1'b0;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    logic        h_last;

    always @(posedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_idx !== h_idx || out_data !== h_data || out_last !== h_last) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%b idx=%0d data=%h last=%b, want v=1 idx=%0d data=%h last=%b",
                             out_valid, out_idx, out_data, out_last, h_idx, h_data, h_last);
                end
            end
            if (out_valid || done) begin
                checks++;
                if ((done && out_valid) || !busy) begin
                    errors++;
                    $display("[TB] FAIL protocol: got done=%b valid=%b busy=%b, want done&valid=0 busy=1",
                             done, out_valid, busy);
                end
            end
            stall_prev = out_valid && !out_ready;
            h_idx      = out_idx;
            h_data     = out_data;
            h_last     = out_last;
        end
    end

    task automatic clear_log();
        q_idx.delete();
        q_data.delete();
        q_last.delete();
        done_count = 0;
    endtask

    // Leaves the DUT one half-cycle after the edge that accepted start.
    task automatic start_dump(input logic s, input logic [4:0] a);
        @(negedge clk);
        start  = 1'b1;
        single = s;
        addr   = a;
        @(negedge clk);
        start  = 1'b0;
        single = 1'b0;
        addr   = 5'd0;
    endtask

    task automatic test_reset();
        logic [45:0] snap;
        rstn = 1'b0;
        @(negedge clk);
        snap = {ra, out_valid, out_idx, out_data, out_last, busy, done};
        checks++;
        if (snap !== 46'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, want 0", snap);
        end
        rstn = 1'b1;
    endtask

    task automatic test_full();
        int n;
        int bad;
        clear_log();
        start_dump(1'b0, 5'd0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || ra !== 5'd0) begin
            errors++;
            $display("[TB] FAIL fetch_state: got valid=%b busy=%b ra=%0d, want 0 1 0", out_valid, busy, ra);
        end
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL first_word: got valid=%b idx=%0d data=%h, want 1 0 00000000",
                             out_valid, out_idx, out_data);
                end
            end
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("[TB] FAIL full_cycles: got %0d, want 64", n);
        end
        checks++;
        if (q_idx.size() != 32) begin
            errors++;
            $display("[TB] FAIL full_count: got %0d, want 32", q_idx.size());
        end
        bad = 0;
        for (int i = 0; i < q_idx.size(); i++) begin
            checks++;
            if (q_idx[i] !== 5'(i) || q_data[i] !== 32'(i) * 32'h01010101 || q_last[i] !== (i == 31)) begin
                errors++;
                $display("[TB] FAIL full_word%0d: got idx=%0d data=%h last=%b, want %0d %h %b",
                         i, q_idx[i], q_data[i], q_last[i], i, 32'(i) * 32'h01010101, (i == 31));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ra !== 5'd0 || done_count != 1) begin
            errors++;
            $display("[TB] FAIL full_done_pulse: got done=%b busy=%b ra=%0d pulses=%0d, want 0 0 0 1",
                     done, busy, ra, done_count);
        end
    endtask

    task automatic test_single();
        int n;
        clear_log();
        rf[7] = 32'hDEADBEEF;
        start_dump(1'b1, 5'd7);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("[TB] FAIL single_cycles: got %0d, want 2", n);
        end
        checks++;
        if (q_idx.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d, want 1", q_idx.size());
        end else begin
            checks++;
            if (q_idx[0] !== 5'd7 || q_data[0] !== 32'hDEADBEEF || q_last[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_word: got idx=%0d data=%h last=%b, want 7 deadbeef 1",
                         q_idx[0], q_data[0], q_last[0]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || done_count != 1) begin
            errors++;
            $display("[TB] FAIL single_idle: got busy=%b done=%b pulses=%0d, want 0 0 1", busy, done, done_count);
        end
        rf[7] = 32'h07070707;
    endtask

    task automatic test_backpressure();
        int n;
        bit stalled;
        clear_log();
        start_dump(1'b0, 5'd0);
        n = 0;
        stalled = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (out_valid && out_idx == 5'd3 && !stalled) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                rf[3]     = 32'hA5A5A5A5;
                repeat (5) @(negedge clk);
                n += 5;
                checks++;
                if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'h03030303 || out_last !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: got v=%b idx=%0d data=%h last=%b, want 1 3 03030303 0",
                             out_valid, out_idx, out_data, out_last);
                end
                out_ready = 1'b1;
            end
        end
        checks++;
        if (n != 69) begin
            errors++;
            $display("[TB] FAIL bp_cycles: got %0d, want 69", n);
        end
        checks++;
        if (q_idx.size() != 32) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d, want 32", q_idx.size());
        end else begin
            checks++;
            if (q_idx[3] !== 5'd3 || q_data[3] !== 32'h03030303 || q_idx[4] !== 5'd4 || q_data[4] !== 32'h04040404) begin
                errors++;
                $display("[TB] FAIL bp_resume: got [3]=%0d/%h [4]=%0d/%h, want 3/03030303 4/04040404",
                         q_idx[3], q_data[3], q_idx[4], q_data[4]);
            end
        end
        rf[3] = 32'h03030303;
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int n;
        bit pulsed;
        int bad;
        clear_log();
        start_dump(1'b0, 5'd0);
        n = 0;
        pulsed = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (out_valid && out_idx == 5'd10 && !pulsed) begin
                pulsed = 1'b1;
                start  = 1'b1;
                single = 1'b1;
                addr   = 5'd5;
            end
        end
        start  = 1'b0;
        single = 1'b0;
        addr   = 5'd0;
        bad = 0;
        for (int i = 0; i < q_idx.size(); i++) begin
            if (q_idx[i] !== 5'(i)) bad++;
        end
        checks++;
        if (n != 64 || q_idx.size() != 32 || bad != 0) begin
            errors++;
            $display("[TB] FAIL busy_start: got cycles=%0d words=%0d misordered=%0d, want 64 32 0",
                     n, q_idx.size(), bad);
        end
        @(negedge clk);
        checks++;
        if (done_count != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_end: got pulses=%0d busy=%b, want 1 0", done_count, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int dc;
        logic [45:0] snap;
        clear_log();
        start_dump(1'b0, 5'd0);
        n = 0;
        while (!(out_valid && out_idx == 5'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd20) begin
            errors++;
            $display("[TB] FAIL reach_idx20: got valid=%b idx=%0d, want 1 20", out_valid, out_idx);
        end
        dc = done_count;
        #2 rstn = 1'b0;
        #1;
        snap = {ra, out_valid, out_idx, out_data, out_last, busy, done};
        checks++;
        if (snap !== 46'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h, want 0", snap);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_count != dc || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got pulses=%0d busy=%b, want %0d 0", done_count, busy, dc);
        end
        clear_log();
        start_dump(1'b0, 5'd0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q_idx.size() != 32 || q_idx[0] !== 5'd0 || n != 64) begin
            errors++;
            $display("[TB] FAIL restart: got words=%0d first=%0d cycles=%0d, want 32 0 64",
                     q_idx.size(), (q_idx.size() > 0) ? q_idx[0] : 5'd31, n);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
        test_reset();
        test_full();
        test_single();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
